// File: rtl/aes128_keyexp_invrow_ark.sv
// AES-128 decryption front end: one-round-per-clock key expansion holding all
// eleven round keys, plus combinational InvShiftRows and AddRoundKey stages.
module aes128_keyexp_invrow_ark (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [127:0]  key,
    input  logic [127:0]  state_in,
    input  logic [3:0]    round_sel,
    output logic [1407:0] round_keys,
    output logic          keys_valid,
    output logic          busy,
    output logic [127:0]  shift_out,
    output logic [127:0]  ark_out
);
    localparam int NR = 10;

    // Forward S-box; entry i sits at bits [2047-8i -: 8].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b111} -: 8];
    endfunction

    logic [127:0] rk [0:NR];
    logic [3:0]   cnt;
    logic [127:0] prev_key;
    logic [127:0] sel_key;
    logic [31:0]  rot_sub;
    logic [31:0]  nw0, nw1, nw2, nw3;
    logic [7:0]   rcon;

    always_comb begin
        rcon = 8'h00;
        case (cnt)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // Next round key derived from the key written on the previous edge.
    always_comb begin
        prev_key = (cnt == 4'd0) ? 128'h0 : rk[cnt - 4'd1];
        rot_sub  = {sbox(prev_key[23:16]), sbox(prev_key[15:8]),
                    sbox(prev_key[7:0]),   sbox(prev_key[31:24])} ^ {rcon, 24'h0};
        nw0 = prev_key[127:96] ^ rot_sub;
        nw1 = prev_key[95:64]  ^ nw0;
        nw2 = prev_key[63:32]  ^ nw1;
        nw3 = prev_key[31:0]   ^ nw2;
    end

    // start is a one-cycle request taken only when not busy; keys_valid stays
    // high (round_keys frozen) until the next accepted start or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r <= NR; r++) rk[r] <= '0;
            cnt        <= 4'd0;
            busy       <= 1'b0;
            keys_valid <= 1'b0;
        end else if (busy) begin
            rk[cnt] <= {nw0, nw1, nw2, nw3};
            if (cnt == 4'(NR)) begin
                busy       <= 1'b0;
                keys_valid <= 1'b1;
                cnt        <= 4'd0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end else if (start) begin
            rk[0]      <= key;
            cnt        <= 4'd1;
            busy       <= 1'b1;
            keys_valid <= 1'b0;
        end
    end

    for (genvar r = 0; r <= NR; r++) begin : g_pack
        assign round_keys[1407-128*r -: 128] = rk[r];
    end

    // Byte 4c+r of the output comes from column (c-r) mod 4 of the same row.
    always_comb begin
        shift_out = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shift_out[127-8*(4*c+r) -: 8] = state_in[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
    end

    always_comb begin
        sel_key = (round_sel > 4'(NR)) ? 128'h0 : rk[round_sel];
        ark_out = state_in ^ sel_key;
    end
endmodule

// File: tb/tb_aes128_keyexp_invrow_ark.sv
// Randomised scoreboard bench for aes128_keyexp_invrow_ark against a GF(2^8)
// based reference model of the key schedule and a matrix model of InvShiftRows.
module tb_aes128_keyexp_invrow_ark;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [127:0]  key = '0;
    logic [127:0]  state_in = '0;
    logic [3:0]    round_sel = '0;
    logic [1407:0] round_keys;
    logic          keys_valid;
    logic          busy;
    logic [127:0]  shift_out;
    logic [127:0]  ark_out;

    int            n_vec = 0;
    int            n_err = 0;
    logic [1407:0] exp_q[$];
    logic [1407:0] cur_keys = '0;
    logic [1407:0] mon_exp;
    logic          prev_valid = 1'b0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

    always #5 clk = ~clk;

    aes128_keyexp_invrow_ark dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key(key),
        .state_in(state_in), .round_sel(round_sel), .round_keys(round_keys),
        .keys_valid(keys_valid), .busy(busy), .shift_out(shift_out), .ark_out(ark_out)
    );

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d = {v, v} << n;
        return d[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse then the affine map.
    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        if (x != 8'h00)
            for (int y = 1; y < 256; y++)
                if (gf_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [1407:0] model_expand(input logic [127:0] k);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        logic [1407:0] ks = '0;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0]), sbox_ref(t[31:24])}
                    ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) ks[1407-32*i -: 32] = w[i];
        return ks;
    endfunction

    function automatic logic [127:0] rk_of(input logic [1407:0] ks, input int r);
        if (r > 10) return '0;
        return ks[1407-128*r -: 128];
    endfunction

    // Row r of the state matrix moves r columns to the right.
    function automatic logic [127:0] inv_shift_ref(input logic [127:0] s);
        logic [7:0]   m [4][4];
        logic [7:0]   o [4][4];
        logic [127:0] res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) m[r][c] = s[127-8*(4*c+r) -: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) o[r][(c+r)%4] = m[r][c];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) res[127-8*(4*c+r) -: 8] = o[r][c];
        return res;
    endfunction

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_keys(input string name, input logic [1407:0] exp);
        for (int r = 0; r <= 10; r++)
            check128($sformatf("%s_rk%0d", name, r), round_keys[1407-128*r -: 128], rk_of(exp, r));
    endtask

    // Monitor: each rising keys_valid must match the oldest accepted expansion.
    always @(negedge clk) begin
        if (keys_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_keys_valid: got 1 expected no pending expansion");
            end else begin
                mon_exp = exp_q.pop_front();
                check_all_keys("mon", mon_exp);
            end
        end
        prev_valid = keys_valid;
    end

    task automatic issue_start(input logic [127:0] k, input bit accept);
        @(posedge clk); #1;
        start = 1'b1;
        key   = k;
        if (accept) begin
            cur_keys = model_expand(k);
            exp_q.push_back(cur_keys);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int already);
        int edges = already;
        while (!keys_valid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        check128({name, "_latency"}, 128'(edges), 128'd10);
        check128({name, "_busy_done"}, 128'(busy), 128'd0);
    endtask

    task automatic datapath_checks(input int n);
        logic [127:0] s;
        int sel;
        for (int i = 0; i < n; i++) begin
            s   = {$urandom, $urandom, $urandom, $urandom};
            sel = $urandom_range(0, 15);
            state_in  = s;
            round_sel = 4'(sel);
            #1;
            check128("shift_rand", shift_out, inv_shift_ref(s));
            check128($sformatf("ark_sel%0d", sel), ark_out, s ^ rk_of(cur_keys, sel));
        end
    endtask

    initial begin
        logic [127:0] k;
        logic [127:0] s;

        // Reset state, with the datapath still live.
        repeat (3) @(posedge clk);
        #1;
        state_in  = 128'h3925841d02dc09fbdc118597196a0b32;
        round_sel = 4'd3;
        #1;
        check128("reset_keys_valid", 128'(keys_valid), 128'd0);
        check128("reset_busy", 128'(busy), 128'd0);
        check_all_keys("reset", '0);
        check128("reset_ark", ark_out, state_in);
        rst_n = 1'b1;

        state_in = SEQ_KEY;
        #1;
        check128("shift_seq", shift_out, 128'h000d0a0704010e0b0805020f0c090603);
        state_in = '1;
        #1;
        check128("shift_ones", shift_out, '1);

        // FIPS-197 key.
        issue_start(FIPS_KEY, 1'b1);
        check128("fips_busy", 128'(busy), 128'd1);
        wait_done("fips", 0);
        check128("fips_rk0", round_keys[1407:1280], FIPS_KEY);
        check128("fips_rk1", round_keys[1279:1152], 128'ha0fafe1788542cb123a339392a6c7605);
        check128("fips_rk10", round_keys[127:0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        s = 128'h3925841d02dc09fbdc118597196a0b32;
        state_in  = s;
        round_sel = 4'd10;
        #1;
        check128("ark_fips_r10", ark_out, s ^ 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        round_sel = 4'd12;
        #1;
        check128("ark_sel12", ark_out, s);
        datapath_checks(12);

        // Key input changes without start leave the stored schedule alone.
        key = {$urandom, $urandom, $urandom, $urandom};
        repeat (5) @(posedge clk);
        #1;
        check128("hold_valid", 128'(keys_valid), 128'd1);
        check_all_keys("hold", cur_keys);

        // Restart while keys_valid is high.
        issue_start(SEQ_KEY, 1'b1);
        check128("restart_valid_drop", 128'(keys_valid), 128'd0);
        wait_done("seq", 0);
        check128("seq_rk10", round_keys[127:0], 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // A start during expansion is ignored.
        issue_start(FIPS_KEY, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        key   = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("ignored", 4);
        check128("ignored_rk10", round_keys[127:0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Asynchronous reset in the middle of an expansion.
        k = {$urandom, $urandom, $urandom, $urandom};
        issue_start(k, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check128("midrst_valid", 128'(keys_valid), 128'd0);
        check128("midrst_busy", 128'(busy), 128'd0);
        check_all_keys("midrst", '0);
        cur_keys = '0;
        datapath_checks(2);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Fresh random keys after the reset.
        for (int i = 0; i < 4; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            issue_start(k, 1'b1);
            wait_done($sformatf("rand%0d", i), 0);
            datapath_checks(3);
        end

        repeat (2) @(posedge clk);
        check128("queue_empty", 128'(exp_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/aes128_keyexp_invrow_ark.md
Name: aes128_keyexp_invrow_ark

Overview:
- AES-128 decryption support block: one-round-per-clock key expansion generating all 11 round keys, plus combinational InvShiftRows and AddRoundKey datapath stages.
- Sits ahead of the inverse-round pipeline.
- The decipher controller loads the cipher key once, waits for keys_valid, then uses the packed key bus and the two datapath outputs each round.

Parameters:
- NR, 10, number of AES rounds; fixed for AES-128, not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  load key and begin expansion; single-cycle pulse.
- key  input  128  cipher key; sampled on the start edge.
- state_in  input  128  128-bit AES state for the datapath stages.
- round_sel  input  4  round-key index for AddRoundKey.
- round_keys  output  1408  packed round keys. Round key r occupies bits [1407-128r -: 128].
  - bits[1407:1280] = round key 0 (the raw key).
  - bits[127:0] = round key 10.
- keys_valid  output  1  all 11 round keys complete and stable.
- busy  output  1  expansion in progress.
- shift_out  output  128  InvShiftRows(state_in), combinational.
- ark_out  output  128  state_in XOR round key[round_sel], combinational.

Behaviour:
- Byte order follows FIPS-197.
  - Byte b0 = bits[127:120], b15 = bits[7:0].
  - Byte index = 4*column + row (column-major).
- InvShiftRows rotates row r right by r positions.
  - Output byte order: b0 b13 b10 b7 | b4 b1 b14 b11 | b8 b5 b2 b15 | b12 b9 b6 b3.
  - Purely combinational, no registers.
- AddRoundKey: ark_out = state_in ^ round key[round_sel].
  - round_sel 11..15 selects an all-zero key, so ark_out = state_in.
- Key expansion, words w[0..43]. For i ≥ 4:
  - If i%4==0: w[i] = w[i-4] ^ SubWord(RotWord(w[i-1])) ^ {Rcon[i/4],24'h0}.
  - Otherwise: w[i] = w[i-4] ^ w[i-1].
  - RotWord is a left byte rotate.
  - SubWord uses the forward AES S-box: 256-entry table, 4 instances.
  - Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- Sequencing, with a round counter of 0..10:
  - Idle + start at edge E0: round key 0 ← key, counter ← 1, busy ← 1, keys_valid ← 0.
  - Each following edge: write round key[counter] from round key[counter-1], then increment the counter.
  - Round key 10 is written on edge E0+10. On that same edge busy ← 0 and keys_valid ← 1.
  - Latency from start to keys_valid is 10 cycles.
- start while busy is ignored; the expansion in progress continues unaffected.
- start while keys_valid=1 restarts expansion.
  - keys_valid drops on that edge.
  - Unwritten round-key slots keep their old values until overwritten.
- The key input is only sampled on the accepted start edge; later changes to key have no effect.
- Reset (rst_n=0, asynchronous):
  - round_keys ← 0, keys_valid ← 0, busy ← 0, counter ← 0.
  - Reset mid-expansion aborts it; a new start is needed.
  - Datapath outputs remain combinational during reset. With round_keys cleared, ark_out = state_in.
- round_keys only changes on clock edges. It is held stable while keys_valid=1.

Test Plan:
- Reset, then start with key=2b7e151628aed2a6abf7158809cf4f3c.
  - busy=1 for 10 cycles; keys_valid=1 exactly 10 cycles after the start edge.
  - round key 1 = a0fafe1788542cb123a339392a6c7605.
  - round key 10 = round_keys[127:0] = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - round_keys[1407:1280] = the key.
- Key 000102030405060708090a0b0c0d0e0f -> round key 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- state_in=000102030405060708090a0b0c0d0e0f -> shift_out=000d0a0704010e0b0805020f0c090603.
  - state_in=all-ones -> shift_out=all-ones.
- After the first key is loaded, round_sel=10, state_in=3925841d02dc09fbdc118597196a0b32 -> ark_out = state_in ^ d014f9a8c9ee2589e13f0cc8b6630ca6.
  - round_sel=12 -> ark_out = state_in.
- Pulse start again at cycle 4 of an expansion with a different key -> ignored; final keys match the first key.
- Assert rst_n=0 at cycle 5 of an expansion.
  - All outputs clear immediately: keys_valid=0, busy=0, round_keys=0.
  - A fresh start then completes in 10 cycles.
